apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- Single-outstanding APB4 requester (initiator) that drives peripheral completers such as the UART, CLINT and GPIO APB slaves.
- Accepts a valid/ready request from a local master (boot loader, debug module, or AHB-to-APB front end).
- Sequences the APB SETUP and ACCESS phases, honours PREADY wait states, and returns read data or an error on a valid/ready response channel.
- A timeout counter guarantees forward progress when a completer never asserts PREADY.

Parameters:
- XLEN, 64, data width; PWDATA/PRDATA width; PSTRB width is XLEN/8.
- ADDR_WIDTH, 32, PADDR width.
- TIMEOUT, 255, maximum number of extra ACCESS cycles without PREADY before error; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  request accepted when ReqValid&ReqReady.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_WIDTH  byte address.
- ReqWData  in  XLEN  write data.
- ReqStrb  in  XLEN/8  write byte strobes.
- RspValid  out  1  response present.
- RspReady  in  1  response consumed when RspValid&RspReady.
- RspRData  out  XLEN  read data; 0 for writes and errors.
- RspErr  out  1  1 = timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  XLEN  APB write data.
- PSTRB  out  XLEN/8  APB strobes.
- PREADY  in  1  completer ready.
- PRDATA  in  XLEN  completer read data.

Behaviour:
- Clocking: one clock, PCLK. Reset PRESETn is asynchronous and active-low. All state and APB outputs are registered.
- Reset values:
  - State is IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, RspValid, RspRData, RspErr are all 0.
  - Timeout counter is 0.
  - ReqReady is 0 while PRESETn is low.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - ReqReady = 1 (combinational from state).
  - On ReqValid, capture ReqWrite, ReqAddr, ReqWData and ReqStrb into the APB output registers, then go to SETUP.
  - For reads, PSTRB is loaded with 0 and PWDATA is loaded with 0.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - Always goes to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE, PWDATA and PSTRB are held stable for the entire phase.
  - PREADY = 1: sample PRDATA into RspRData (write: RspRData = 0), set RspErr = 0, clear PSEL/PENABLE, go to RESP.
  - PREADY = 0, TIMEOUT != 0, and counter == TIMEOUT: set RspErr = 1, RspRData = 0, clear PSEL/PENABLE, go to RESP.
  - Otherwise, increment the counter and stay in ACCESS.
  - The counter clears on entry to SETUP.
  - ACCESS therefore lasts at most TIMEOUT+1 cycles.
- RESP:
  - RspValid = 1; RspRData and RspErr are held stable.
  - ReqReady = 0.
  - On RspReady, clear RspValid and go to IDLE.
- Latency and throughput:
  - Zero-wait completer: request accept (cycle 0) -> SETUP (1) -> ACCESS (2) -> RspValid (3).
  - Minimum 4 cycles per transfer; only one transfer is outstanding.
- Address and data handling:
  - No alignment check; PADDR is passed through unmodified.
  - PRDATA is captured full width, with no lane extraction (the completer replicates bytes as needed).
- Boundary conditions:
  - PREADY high during SETUP is ignored.
  - ReqValid asserted outside IDLE is not accepted; the request must be held by the master.
  - Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronously), the transfer is abandoned, and no response is produced.
  - Counter width is clog2(TIMEOUT+1), minimum 1 bit. It cannot wrap because it stops at TIMEOUT.

Test Plan:
- Write with XLEN=64 against the UART APB completer (PREADY=1):
  - Stimulus: Req write, addr 0x10000000, ReqWData = 0x41 in lane 0, ReqStrb = 0x01.
  - Response: one cycle with PSEL=1/PENABLE=0, then one with PSEL=PENABLE=1, PADDR=0x10000000, PWDATA[7:0]=0x41.
  - RspValid three cycles after accept, with RspErr=0 and RspRData=0.
- Read of the UART LSR:
  - Stimulus: addr 0x10000005, completer returns PRDATA=0x6060606060606060.
  - Response: PSTRB=0, PWRITE=0, RspRData=0x6060606060606060, RspErr=0.
- Wait states:
  - Stimulus: stub completer holds PREADY low for 3 ACCESS cycles.
  - Response: PENABLE high for 4 cycles; PADDR/PWDATA/PSTRB/PWRITE unchanged throughout; correct data returned.
- Timeout:
  - Stimulus: TIMEOUT=4, PREADY tied low.
  - Response: ACCESS lasts exactly 5 cycles, then PSEL=0, RspValid=1, RspErr=1, RspRData=0.
  - Repeat with TIMEOUT=0 and PREADY low for 1000 cycles: no response, PSEL remains 1.
- Backpressure:
  - Stimulus: RspReady low for 5 cycles after RspValid while a second ReqValid is pending.
  - Response: RspValid and data held for 5 cycles; ReqReady=0; the second request is accepted in the cycle after the RspValid&RspReady handshake.
- Reset mid-ACCESS:
  - Stimulus: assert PRESETn low asynchronously during ACCESS.
  - Response: PSEL/PENABLE go to 0 without waiting for a PCLK edge, no RspValid ever appears, and after release ReqReady=1 in IDLE.

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding transfer at a time.
// A local valid/ready request is turned into APB SETUP and ACCESS phases.
// PREADY wait states are honoured. The result comes back on a valid/ready
// response channel. A bounded ACCESS phase turns a completer that never
// answers into an error response instead of a hang.
module apb_requester #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [XLEN-1:0]       ReqWData,
    input  logic [XLEN/8-1:0]     ReqStrb,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [XLEN-1:0]       RspRData,
    output logic                  RspErr,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [XLEN-1:0]       PWDATA,
    output logic [XLEN/8-1:0]     PSTRB,
    input  logic                  PREADY,
    input  logic [XLEN-1:0]       PRDATA
);

    // The counter saturates at TIMEOUT, so it never needs more than this width.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             accept;
    logic             access_done;

    // Next-state logic, handshake qualifiers and the request-ready output.
    always_comb begin
        state_nx    = state;
        timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_MAX);
        accept      = (state == IDLE) && ReqValid;
        access_done = (state == ACCESS) && (PREADY || timeout_hit);
        // Ready is forced low while reset is held, even though the state reads IDLE.
        ReqReady    = PRESETn && (state == IDLE);
        case (state)
            IDLE:    if (ReqValid) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nx = RESP;
            RESP:    if (RspReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Wait-state counter: cleared on acceptance, counts ACCESS cycles without PREADY.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // APB outputs: the request is captured on acceptance and held until the transfer ends.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
        end else if (accept) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= ReqWrite;
            PADDR   <= ReqAddr;
            // Reads drive no write lanes, so the completer never sees stale data.
            PWDATA  <= ReqWrite ? ReqWData : '0;
            PSTRB   <= ReqWrite ? ReqStrb : '0;
        end else if (state == SETUP) begin
            PENABLE <= 1'b1;
        end else if (access_done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end
    end

    // Response channel: loaded when ACCESS ends, held until the master consumes it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            RspValid <= 1'b0;
            RspRData <= '0;
            RspErr   <= 1'b0;
        end else if ((state == ACCESS) && PREADY) begin
            RspValid <= 1'b1;
            RspErr   <= 1'b0;
            RspRData <= PWRITE ? '0 : PRDATA;
        end else if ((state == ACCESS) && timeout_hit) begin
            RspValid <= 1'b1;
            RspErr   <= 1'b1;
            RspRData <= '0;
        end else if ((state == RESP) && RspReady) begin
            RspValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester. Instance a uses a short timeout.
// Instance b has the timeout disabled.
module tb_apb_requester;

    logic        PCLK;
    logic        PRESETn;

    logic        ReqValid, ReqReady, ReqWrite;
    logic [31:0] ReqAddr;
    logic [63:0] ReqWData;
    logic [7:0]  ReqStrb;
    logic        RspValid, RspReady, RspErr;
    logic [63:0] RspRData;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR;
    logic [63:0] PWDATA, PRDATA;
    logic [7:0]  PSTRB;

    logic        b_reqvalid, b_reqready, b_reqwrite;
    logic [31:0] b_reqaddr;
    logic [63:0] b_reqwdata;
    logic [7:0]  b_reqstrb;
    logic        b_rspvalid, b_rspready, b_rsperr;
    logic [63:0] b_rsprdata;
    logic        b_psel, b_penable, b_pwrite, b_pready;
    logic [31:0] b_paddr;
    logic [63:0] b_pwdata, b_prdata;
    logic [7:0]  b_pstrb;

    int npass  = 0;
    int ntotal = 0;

    apb_requester #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(4)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
        .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData), .RspErr(RspErr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    apb_requester #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(0)) u_dut_nto (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .ReqValid(b_reqvalid), .ReqReady(b_reqready), .ReqWrite(b_reqwrite),
        .ReqAddr(b_reqaddr), .ReqWData(b_reqwdata), .ReqStrb(b_reqstrb),
        .RspValid(b_rspvalid), .RspReady(b_rspready), .RspRData(b_rsprdata), .RspErr(b_rsperr),
        .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
        .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PREADY(b_pready), .PRDATA(b_prdata)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] strb);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = addr;
        ReqWData = wd;
        ReqStrb  = strb;
    endtask

    initial begin
        int bad_cycles;
        int rsp_seen;

        PRESETn  = 1'b0;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0; ReqStrb = '0;
        RspReady = 1'b1; PREADY = 1'b0; PRDATA = '0;
        b_reqvalid = 1'b0; b_reqwrite = 1'b0; b_reqaddr = '0; b_reqwdata = '0;
        b_reqstrb = '0; b_rspready = 1'b1; b_pready = 1'b0; b_prdata = '0;

        // Reset state
        step(); step();
        chk("rst_reqready", ReqReady, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_rsperr", RspErr, 0);
        chk("rst_rsprdata", RspRData, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pstrb", PSTRB, 0);
        #4 PRESETn = 1'b1;
        step();
        chk("idle_reqready", ReqReady, 1);

        // Zero-wait write to the UART THR
        PREADY = 1'b1;
        req(1'b1, 32'h1000_0000, 64'h41, 8'h01);
        step();
        ReqValid = 1'b0;
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_reqready", ReqReady, 0);
        step();
        chk("wr_acc_psel", PSEL, 1);
        chk("wr_acc_penable", PENABLE, 1);
        chk("wr_acc_paddr", PADDR, 64'h1000_0000);
        chk("wr_acc_pwdata", PWDATA, 64'h41);
        chk("wr_acc_pstrb", PSTRB, 8'h01);
        chk("wr_acc_pwrite", PWRITE, 1);
        chk("wr_acc_rspvalid", RspValid, 0);
        step();
        chk("wr_rsp_valid", RspValid, 1);
        chk("wr_rsp_err", RspErr, 0);
        chk("wr_rsp_rdata", RspRData, 0);
        chk("wr_rsp_psel", PSEL, 0);
        step();
        chk("wr_done_rspvalid", RspValid, 0);
        chk("wr_done_reqready", ReqReady, 1);

        // Read of the UART LSR; write data/strobes offered with a read must not leak
        PRDATA = 64'h6060_6060_6060_6060;
        req(1'b0, 32'h1000_0005, 64'hdead_beef_cafe_f00d, 8'hff);
        step();
        ReqValid = 1'b0;
        step();
        chk("rd_acc_pwrite", PWRITE, 0);
        chk("rd_acc_pstrb", PSTRB, 0);
        chk("rd_acc_pwdata", PWDATA, 0);
        chk("rd_acc_paddr", PADDR, 64'h1000_0005);
        step();
        chk("rd_rsp_valid", RspValid, 1);
        chk("rd_rsp_rdata", RspRData, 64'h6060_6060_6060_6060);
        chk("rd_rsp_err", RspErr, 0);
        step();

        // Three wait states; PREADY high during SETUP must be ignored
        PRDATA = 64'h0123_4567_89ab_cdef;
        req(1'b1, 32'h1000_1008, 64'h1122_3344_5566_7788, 8'hf0);
        step();
        ReqValid = 1'b0;
        chk("ws_setup_penable", PENABLE, 0);
        PREADY = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            PREADY = (i == 3);
            chk($sformatf("ws_acc%0d_penable", i), PENABLE, 1);
            chk($sformatf("ws_acc%0d_paddr", i), PADDR, 64'h1000_1008);
            chk($sformatf("ws_acc%0d_pwdata", i), PWDATA, 64'h1122_3344_5566_7788);
            chk($sformatf("ws_acc%0d_pstrb", i), PSTRB, 8'hf0);
            chk($sformatf("ws_acc%0d_pwrite", i), PWRITE, 1);
            chk($sformatf("ws_acc%0d_rspvalid", i), RspValid, 0);
            step();
        end
        chk("ws_rsp_valid", RspValid, 1);
        chk("ws_rsp_err", RspErr, 0);
        chk("ws_rsp_rdata", RspRData, 0);
        chk("ws_rsp_penable", PENABLE, 0);
        step();

        // Wait-state read returning data
        req(1'b0, 32'h1000_2000, 64'h0, 8'h00);
        step();
        ReqValid = 1'b0;
        PREADY = 1'b0;
        step(); step(); step();
        chk("wsr_acc_penable", PENABLE, 1);
        PREADY = 1'b1;
        step();
        chk("wsr_rsp_rdata", RspRData, 64'h0123_4567_89ab_cdef);
        chk("wsr_rsp_err", RspErr, 0);
        step();

        // Timeout with PREADY tied low: five ACCESS cycles, then an error response
        PREADY = 1'b0;
        PRDATA = 64'hffff_ffff_ffff_ffff;
        req(1'b0, 32'h1000_3000, 64'h0, 8'h00);
        step();
        ReqValid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("to_acc%0d_psel", i), PSEL, 1);
            chk($sformatf("to_acc%0d_penable", i), PENABLE, 1);
            chk($sformatf("to_acc%0d_rspvalid", i), RspValid, 0);
            step();
        end
        chk("to_rsp_psel", PSEL, 0);
        chk("to_rsp_valid", RspValid, 1);
        chk("to_rsp_err", RspErr, 1);
        chk("to_rsp_rdata", RspRData, 0);
        step();

        // Backpressure with a second request already pending
        PREADY = 1'b1;
        PRDATA = 64'ha5a5_a5a5_5a5a_5a5a;
        RspReady = 1'b0;
        req(1'b0, 32'h1000_4000, 64'h0, 8'h00);
        step();
        req(1'b1, 32'h1000_4010, 64'h77, 8'h01);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rspvalid", i), RspValid, 1);
            chk($sformatf("bp%0d_rdata", i), RspRData, 64'ha5a5_a5a5_5a5a_5a5a);
            chk($sformatf("bp%0d_reqready", i), ReqReady, 0);
            chk($sformatf("bp%0d_psel", i), PSEL, 0);
            step();
        end
        RspReady = 1'b1;
        chk("bp_hs_rspvalid", RspValid, 1);
        step();
        chk("bp_idle_rspvalid", RspValid, 0);
        chk("bp_idle_reqready", ReqReady, 1);
        chk("bp_idle_psel", PSEL, 0);
        step();
        ReqValid = 1'b0;
        chk("bp_2nd_psel", PSEL, 1);
        chk("bp_2nd_penable", PENABLE, 0);
        chk("bp_2nd_paddr", PADDR, 64'h1000_4010);
        chk("bp_2nd_pwrite", PWRITE, 1);
        step();
        step();
        chk("bp_2nd_rspvalid", RspValid, 1);
        chk("bp_2nd_rdata", RspRData, 0);
        step();

        // Reset asserted in the middle of ACCESS
        PREADY = 1'b0;
        req(1'b0, 32'h1000_5000, 64'h0, 8'h00);
        step();
        ReqValid = 1'b0;
        step();
        chk("rm_acc_penable", PENABLE, 1);
        #3 PRESETn = 1'b0;
        #1;
        chk("rm_async_psel", PSEL, 0);
        chk("rm_async_penable", PENABLE, 0);
        chk("rm_async_reqready", ReqReady, 0);
        step();
        #3 PRESETn = 1'b1;
        PREADY = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RspValid !== 1'b0) rsp_seen++;
        end
        chk("rm_no_rsp", rsp_seen, 0);
        chk("rm_idle_reqready", ReqReady, 1);
        chk("rm_idle_psel", PSEL, 0);

        // Timeout disabled: a silent completer keeps the transfer open
        b_reqvalid = 1'b1;
        b_reqwrite = 1'b0;
        b_reqaddr  = 32'h0200_0000;
        step();
        b_reqvalid = 1'b0;
        step();
        bad_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if ((b_psel !== 1'b1) || (b_penable !== 1'b1) || (b_rspvalid !== 1'b0))
                bad_cycles++;
            step();
        end
        chk("nto_bad_cycles", bad_cycles, 0);
        chk("nto_psel", b_psel, 1);
        chk("nto_rspvalid", b_rspvalid, 0);
        chk("nto_reqready", b_reqready, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
